// File: rtl/seg_pkg.sv
// Shared glyphs, message codes, FSM states and sizing helper for the seven-segment controller.
// Glyph bit order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_DARK  = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_Q     = 7'b0011000;
    localparam logic [6:0] SEG_Y     = 7'b0010001;

    typedef enum logic [2:0] {
        MSG_BLANK = 3'd0,
        MSG_PLAY  = 3'd1,
        MSG_IDLE  = 3'd2,
        MSG_EQ    = 3'd3,
        MSG_DB    = 3'd4,
        MSG_HZ    = 3'd5
    } msg_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONV    = 2'd1,
        ST_COMPOSE = 2'd2
    } state_e;

    // Decimal digits needed for the largest magnitude, 2^(w-1).
    function automatic int bcd_digits(input int w);
        longint m;
        int     n;
        m = longint'(1) << (w - 1);
        n = 0;
        do begin
            n++;
            m = m / 10;
        end while (m != 0);
        return n;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DARK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial double-dabble binary-to-BCD converter: one input bit per cycle, W cycles per conversion.
// o_done is high during the final shift cycle; o_bcd is valid from the next cycle until the next start.
module bcd_serial_conv
    import seg_pkg::*;
#(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [W-1:0]    i_bin,
    output logic            o_done,
    output logic [4*ND-1:0] o_bcd
);

    localparam int CW = $clog2(W + 1);

    logic [4*ND+W-1:0] sh_q, sh_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        adj   = sh_q;
        if (i_start) begin
            sh_d  = {{(4*ND){1'b0}}, i_bin};
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            for (int j = 0; j < ND; j++) begin
                if (adj[W+4*j +: 4] >= 4'd5) begin
                    adj[W+4*j +: 4] = adj[W+4*j +: 4] + 4'd3;
                end
            end
            sh_d  = adj << 1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == CW'(1));
    assign o_bcd  = sh_q[W +: 4*ND];

endmodule

// File: rtl/seg_display_ctrl.sv
// Message/number renderer for a multi-digit seven-segment display (active-low segments).
// Optional blink output stage is built when SEG_BLINK_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for i_load; o_seg holds last render
// ST_CONV    | serial BCD conversion of |value| in progress
// ST_COMPOSE | build glyphs, register o_seg, pulse o_done
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int VAL_W       = 8,
    parameter int BLINK_TICKS = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tick,
    input  logic                    i_load,
    input  logic [2:0]              i_msg,
    input  logic [VAL_W-1:0]        i_value,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    output logic [7*NUM_DIGITS-1:0] o_seg,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int ND = bcd_digits(VAL_W);

    generate
        if (NUM_DIGITS < ND + 3) begin : g_size_check
            $error("seg_display_ctrl: NUM_DIGITS too small for VAL_W");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [2:0]              msg_q, msg_d;
    logic [VAL_W-1:0]        val_q, val_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d, seg_c;
    logic                    done_q, done_d;

    logic                    numeric_load, conv_start, conv_done, neg;
    logic [VAL_W-1:0]        mag;
    logic [4*ND-1:0]         bcd;
    int                      msd;

    assign numeric_load = (i_msg == MSG_DB) || (i_msg == MSG_HZ);
    assign conv_start   = (state_q == ST_IDLE) && i_load && numeric_load;
    // Unsigned magnitude so the most negative value maps to 2^(VAL_W-1).
    assign mag          = i_value[VAL_W-1] ? (~i_value + VAL_W'(1)) : i_value;
    assign neg          = val_q[VAL_W-1];

    bcd_serial_conv #(.W(VAL_W), .ND(ND)) u_conv (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (conv_start),
        .i_bin   (mag),
        .o_done  (conv_done),
        .o_bcd   (bcd)
    );

    always_comb begin
        seg_c = '1;
        msd   = 0;
        case (msg_q)
            MSG_PLAY: begin
                seg_c[7*3 +: 7] = SEG_P;
                seg_c[7*2 +: 7] = SEG_L;
                seg_c[7*1 +: 7] = SEG_A;
                seg_c[7*0 +: 7] = SEG_Y;
            end
            MSG_IDLE: begin
                seg_c[7*3 +: 7] = SEG_I;
                seg_c[7*2 +: 7] = SEG_D;
                seg_c[7*1 +: 7] = SEG_L;
                seg_c[7*0 +: 7] = SEG_E;
            end
            MSG_EQ: begin
                seg_c[7*1 +: 7] = SEG_E;
                seg_c[7*0 +: 7] = SEG_Q;
            end
            MSG_DB, MSG_HZ: begin
                for (int j = 0; j < ND; j++) begin
                    if (bcd[4*j +: 4] != 4'd0) msd = j;
                end
                for (int j = 0; j < ND; j++) begin
                    if (j <= msd) seg_c[7*(j+2) +: 7] = digit_glyph(bcd[4*j +: 4]);
                end
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (neg && (k == msd + 3)) seg_c[7*k +: 7] = SEG_MINUS;
                end
                seg_c[7*1 +: 7] = (msg_q == MSG_DB) ? SEG_D : SEG_H;
                seg_c[7*0 +: 7] = (msg_q == MSG_DB) ? SEG_B : SEG_2;
            end
            default: seg_c = '1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        val_d   = val_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    msg_d   = i_msg;
                    val_d   = i_value;
                    state_d = numeric_load ? ST_CONV : ST_COMPOSE;
                end
            end
            ST_CONV: begin
                if (conv_done) state_d = ST_COMPOSE;
            end
            ST_COMPOSE: begin
                seg_d   = seg_c;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            msg_q   <= '0;
            val_q   <= '0;
            seg_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            val_q   <= val_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [7*NUM_DIGITS-1:0] out_q, out_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (i_tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        // Blanking only masks the output copy; seg_q keeps the rendered pattern.
        out_d = seg_d;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (phase_d && i_blink_mask[k]) out_d[7*k +: 7] = SEG_DARK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            out_q       <= '1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            out_q       <= out_d;
        end
    end

    assign o_seg = out_q;
`else
    logic unused_blink;
    assign unused_blink = ^{i_tick, i_blink_mask, (BLINK_TICKS > 0)};
    assign o_seg        = seg_q;
`endif

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl (NUM_DIGITS=8, VAL_W=8); blink steps run when SEG_BLINK_EN is defined.
module tb_seg_display_ctrl;

    localparam int NDIG = 8;
    localparam int VW   = 8;

    localparam logic [6:0] G_DK = 7'b1111111;
    localparam logic [6:0] G_MI = 7'b0111111;
    localparam logic [6:0] G_0  = 7'b1000000;
    localparam logic [6:0] G_1  = 7'b1111001;
    localparam logic [6:0] G_2  = 7'b0100100;
    localparam logic [6:0] G_5  = 7'b0010010;
    localparam logic [6:0] G_7  = 7'b1111000;
    localparam logic [6:0] G_8  = 7'b0000000;
    localparam logic [6:0] G_9  = 7'b0010000;
    localparam logic [6:0] G_A  = 7'b0001000;
    localparam logic [6:0] G_B  = 7'b0000011;
    localparam logic [6:0] G_D  = 7'b0100001;
    localparam logic [6:0] G_E  = 7'b0000110;
    localparam logic [6:0] G_H  = 7'b0001001;
    localparam logic [6:0] G_I  = 7'b1111001;
    localparam logic [6:0] G_L  = 7'b1000111;
    localparam logic [6:0] G_P  = 7'b0001100;
    localparam logic [6:0] G_Q  = 7'b0011000;
    localparam logic [6:0] G_Y  = 7'b0010001;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_tick;
    logic                 i_load;
    logic [2:0]           i_msg;
    logic [VW-1:0]        i_value;
    logic [NDIG-1:0]      i_blink_mask;
    logic [7*NDIG-1:0]    o_seg;
    logic                 o_busy;
    logic                 o_done;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    seg_display_ctrl #(
        .NUM_DIGITS  (NDIG),
        .VAL_W       (VW),
        .BLINK_TICKS (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .i_load       (i_load),
        .i_msg        (i_msg),
        .i_value      (i_value),
        .i_blink_mask (i_blink_mask),
        .o_seg        (o_seg),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] disp(input logic [6:0] d7, input logic [6:0] d6,
                                         input logic [6:0] d5, input logic [6:0] d4,
                                         input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return 64'({d7, d6, d5, d4, d3, d2, d1, d0});
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [2:0] code, input logic [VW-1:0] v);
        i_load  = 1'b1;
        i_msg   = code;
        i_value = v;
        step();
        i_load  = 1'b0;
    endtask

    // Cycles after the load edge until o_done is seen; gives up at 40.
    task automatic wait_done(output int n);
        n = 0;
        while (!o_done && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic count_dones(input int cycles, output int dones);
        dones = 0;
        for (int c = 0; c < cycles; c++) begin
            if (o_done) dones++;
            step();
        end
    endtask

    initial begin
        int n;
        int dones;
        logic [63:0] base;
        logic [63:0] exp;
        i_rst        = 1'b1;
        i_tick       = 1'b0;
        i_load       = 1'b0;
        i_msg        = 3'd0;
        i_value      = '0;
        i_blink_mask = '0;
        step();
        step();
        check("rst_seg", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_DK, G_DK, G_DK, G_DK));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        i_rst = 1'b0;
        step();

        // -12 in dB
        load(3'd4, 8'hF4);
        check("busy_conv", 64'(o_busy), 64'(1));
        wait_done(n);
        check("lat_m12", 64'(n), 64'(9));
        check("seg_m12", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_MI, G_1, G_2, G_D, G_B));
        step();
        check("done_pulse", 64'(o_done), 64'(0));
        check("busy_after", 64'(o_busy), 64'(0));

        // most negative value
        load(3'd4, 8'h80);
        wait_done(n);
        check("lat_m128", 64'(n), 64'(9));
        check("seg_m128", 64'(o_seg), disp(G_DK, G_DK, G_MI, G_1, G_2, G_8, G_D, G_B));

        load(3'd5, 8'h00);
        wait_done(n);
        check("seg_zero_hz", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_DK, G_0, G_H, G_2));

        // text latency and hold
        load(3'd1, 8'h00);
        wait_done(n);
        check("lat_play", 64'(n), 64'(1));
        check("seg_play", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_P, G_L, G_A, G_Y));
        check("busy_play", 64'(o_busy), 64'(0));
        for (int c = 0; c < 5; c++) step();
        check("hold_play", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_P, G_L, G_A, G_Y));

        // loads while busy are dropped
        i_load  = 1'b1;
        i_msg   = 3'd4;
        i_value = 8'd5;
        step();
        i_msg   = 3'd1;
        step();
        step();
        step();
        i_load  = 1'b0;
        count_dones(14, dones);
        check("busy_ignore_dones", 64'(dones), 64'(1));
        check("seg_5db", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_DK, G_5, G_D, G_B));
        check("idle_after_ignore", 64'(o_busy), 64'(0));

        // reset in CONV cycle 4
        load(3'd4, 8'd77);
        step();
        step();
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        count_dones(15, dones);
        check("abort_dones", 64'(dones), 64'(0));
        check("abort_seg", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_DK, G_DK, G_DK, G_DK));
        check("abort_busy", 64'(o_busy), 64'(0));
        load(3'd2, 8'h00);
        wait_done(n);
        check("lat_idle", 64'(n), 64'(1));
        check("seg_idle", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_I, G_D, G_L, G_E));

        load(3'd3, 8'h00);
        wait_done(n);
        check("seg_eq", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_DK, G_DK, G_E, G_Q));

        load(3'd6, 8'h00);
        wait_done(n);
        check("lat_unknown", 64'(n), 64'(1));
        check("seg_unknown", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_DK, G_DK, G_DK, G_DK));

        load(3'd5, 8'd99);
        wait_done(n);
        check("seg_99hz", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_DK, G_9, G_9, G_H, G_2));

        load(3'd4, 8'd127);
        wait_done(n);
        check("lat_127", 64'(n), 64'(9));
        check("seg_127db", 64'(o_seg), disp(G_DK, G_DK, G_DK, G_1, G_2, G_7, G_D, G_B));
        step();

`ifdef SEG_BLINK_EN
        base         = disp(G_DK, G_DK, G_DK, G_1, G_2, G_7, G_D, G_B);
        i_blink_mask = 8'b0000_0011;
        i_tick       = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            exp = base;
            if (((e / 2) % 2) == 1) exp[13:0] = 14'h3FFF;
            check($sformatf("blink_e%0d", e), 64'(o_seg), exp);
        end
        i_tick = 1'b0;
`else
        base = '0;
        exp  = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
